// File: rtl/mem_ram_dp_pkg.sv
// Shared definitions for the dual-port data RAM: sequencer state codes and default widths.
package mem_ram_dp_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

endpackage

// File: rtl/mem_ram_dp_clear_seq.sv
// Clear sequencer: sweeps addresses 0..DEPTH-1 after reset or on a CLEAR request,
// holding busy high for exactly DEPTH cycles.
module mem_clear_seq
  import mem_ram_dp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  output logic              busy_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        // Leave on the edge that writes the last word; the counter never wraps.
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clear_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  assign busy_o     = (state_q == ST_CLEAR);
  assign clr_we_o   = (state_q == ST_CLEAR);
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/mem_ram_dp.sv
// Simple dual-port synchronous RAM with registered read, read-valid strobe,
// selectable read-during-write behaviour and a hardware clear sweep.
module mem_ram_dp
  import mem_ram_dp_pkg::*;
#(
  parameter int                  DATA_W    = DATA_W_DEF,
  parameter int                  ADDR_W    = ADDR_W_DEF,
  parameter int                  DEPTH     = 32,
  parameter bit                  WR_FIRST  = 1'b1,
  parameter logic [DATA_W-1:0]   CLEAR_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  output logic              busy_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] d_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] q_o,
  output logic              q_valid_o
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_ok, rd_ok;
  logic [DATA_W-1:0] q_q, q_d;
  logic              q_valid_q, q_valid_d;

  mem_clear_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear_seq (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (clear_i),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  assign wr_ok = ({1'b0, waddr_i} < DEPTH_W);
  assign rd_ok = ({1'b0, raddr_i} < DEPTH_W);

  // The sweep owns the write port while busy; user writes are simply dropped.
  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem[clr_addr] <= CLEAR_VAL;
    end else if (we_i && wr_ok) begin
      mem[waddr_i] <= d_i;
    end
  end

  always_comb begin
    q_d       = q_q;
    q_valid_d = 1'b0;
    if (!busy && re_i) begin
      q_valid_d = 1'b1;
      if (!rd_ok) begin
        q_d = '0;
      end else if (WR_FIRST && we_i && wr_ok && (waddr_i == raddr_i)) begin
        q_d = d_i;
      end else begin
        q_d = mem[raddr_i];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
    end
  end

  assign busy_o    = busy;
  assign q_o       = q_q;
  assign q_valid_o = q_valid_q;

endmodule

// File: tb/tb_mem_ram_dp.sv
// Randomised and directed bench for mem_ram_dp: three instances (default,
// read-first, shallow DEPTH=20) share stimulus and are checked against a word-level model.
module tb_mem_ram_dp;

  localparam int N = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            clear = 1'b0;
  logic            we = 1'b0;
  logic            re = 1'b0;
  logic [4:0]      waddr = '0;
  logic [4:0]      raddr = '0;
  logic [7:0]      d = '0;
  logic [N-1:0]    busy;
  logic [N-1:0]    qv;
  logic [N-1:0][7:0] q;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] mm [N][32];
  int         left [N];
  logic [7:0] mq [N];
  logic       mqv [N];

  always #5 clk = ~clk;

  mem_ram_dp #(.DEPTH(32), .WR_FIRST(1'b1)) u_wf (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .busy_o(busy[0]),
    .we_i(we), .waddr_i(waddr), .d_i(d), .re_i(re), .raddr_i(raddr),
    .q_o(q[0]), .q_valid_o(qv[0]));

  mem_ram_dp #(.DEPTH(32), .WR_FIRST(1'b0)) u_rf (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .busy_o(busy[1]),
    .we_i(we), .waddr_i(waddr), .d_i(d), .re_i(re), .raddr_i(raddr),
    .q_o(q[1]), .q_valid_o(qv[1]));

  mem_ram_dp #(.DEPTH(20), .WR_FIRST(1'b1)) u_d20 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .busy_o(busy[2]),
    .we_i(we), .waddr_i(waddr), .d_i(d), .re_i(re), .raddr_i(raddr),
    .q_o(q[2]), .q_valid_o(qv[2]));

  function automatic int dep_of(int k);
    return (k == 2) ? 20 : 32;
  endfunction

  function automatic bit wf_of(int k);
    return (k != 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h @%0t", tag, act, exp, $time);
    end
  endtask

  // Reset: the sweep zeroes the array before any access can observe it.
  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      left[k] = dep_of(k);
      mq[k]   = '0;
      mqv[k]  = 1'b0;
      for (int a = 0; a < 32; a++) mm[k][a] = '0;
    end
  endtask

  task automatic model_step(input int k);
    if (left[k] > 0) begin
      left[k]--;
      mqv[k] = 1'b0;
    end else begin
      if (re) begin
        mqv[k] = 1'b1;
        if (int'(raddr) >= dep_of(k)) mq[k] = '0;
        else if (we && waddr == raddr && wf_of(k)) mq[k] = d;
        else mq[k] = mm[k][raddr];
      end else begin
        mqv[k] = 1'b0;
      end
      if (we && int'(waddr) < dep_of(k)) mm[k][waddr] = d;
      if (clear) begin
        for (int a = 0; a < 32; a++) mm[k][a] = '0;
        left[k] = dep_of(k);
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(left[k] > 0));
      chk($sformatf("qv%0d", k), 32'(qv[k]), 32'(mqv[k]));
      chk($sformatf("q%0d", k), 32'(q[k]), 32'(mq[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else for (int k = 0; k < N; k++) model_step(k);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    model_reset();
    tick();
    chk("rst_busy", 32'(busy[0]), 32'd1);
    chk("rst_q", 32'(q[0]), 32'd0);
    tick();
    rst = 1'b0;
    repeat (31) tick();
    chk("sweep31_busy", 32'(busy[0]), 32'd1);
    tick();
    chk("sweep32_idle", 32'(busy[0]), 32'd0);

    // read back every word after the power-on sweep
    re = 1'b1;
    for (int i = 0; i < 32; i++) begin
      raddr = 5'(i);
      tick();
      chk("t1_q", 32'(q[0]), 32'h00);
      chk("t1_qv", 32'(qv[0]), 32'd1);
    end
    re = 1'b0;

    we = 1'b1; waddr = 5'd3; d = 8'hA5;
    tick();
    we = 1'b0;
    tick();
    re = 1'b1; raddr = 5'd3;
    tick();
    chk("t2_q", 32'(q[0]), 32'hA5);
    chk("t2_qv", 32'(qv[0]), 32'd1);
    re = 1'b0;
    tick();
    chk("t2_hold_q", 32'(q[0]), 32'hA5);
    chk("t2_hold_qv", 32'(qv[0]), 32'd0);

    // same-address read and write in one cycle
    we = 1'b1; waddr = 5'd7; d = 8'h11;
    tick();
    d = 8'h3C; re = 1'b1; raddr = 5'd7;
    tick();
    chk("t3_wf", 32'(q[0]), 32'h3C);
    chk("t3_rf", 32'(q[1]), 32'h11);
    we = 1'b0;
    tick();
    chk("t3_rf_after", 32'(q[1]), 32'h3C);
    re = 1'b0;

    // fill, clear, write during sweep dropped
    we = 1'b1; d = 8'hFF;
    for (int i = 0; i < 32; i++) begin
      waddr = 5'(i);
      tick();
    end
    we = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0; we = 1'b1; waddr = 5'd5; d = 8'hAB;
    repeat (10) tick();
    we = 1'b0;
    repeat (21) tick();
    chk("t4_busy_last", 32'(busy[0]), 32'd1);
    tick();
    chk("t4_idle", 32'(busy[0]), 32'd0);
    re = 1'b1;
    for (int i = 0; i < 32; i++) begin
      raddr = 5'(i);
      tick();
      chk("t4_q", 32'(q[0]), 32'h00);
    end
    re = 1'b0;

    // reset in the middle of a sweep
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (10) tick();
    #2 rst = 1'b1;
    #1 model_reset();
    chk("t5_q", 32'(q[0]), 32'd0);
    chk("t5_qv", 32'(qv[0]), 32'd0);
    check_all();
    tick();
    rst = 1'b0;
    repeat (31) tick();
    chk("t5_busy_last", 32'(busy[0]), 32'd1);
    tick();
    chk("t5_idle", 32'(busy[0]), 32'd0);

    // out-of-range access on the shallow instance
    we = 1'b1; waddr = 5'd25; d = 8'h77;
    tick();
    we = 1'b0; re = 1'b1; raddr = 5'd25;
    tick();
    chk("t6_q", 32'(q[2]), 32'h00);
    chk("t6_qv", 32'(qv[2]), 32'd1);
    chk("t6_q_full", 32'(q[0]), 32'h77);
    re = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (19) tick();
    chk("t6_busy19", 32'(busy[2]), 32'd1);
    tick();
    chk("t6_idle20", 32'(busy[2]), 32'd0);
    chk("t6_full_busy", 32'(busy[0]), 32'd1);
    repeat (12) tick();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      we    = 1'($urandom_range(0, 1));
      re    = 1'($urandom_range(0, 1));
      waddr = 5'($urandom_range(0, 31));
      raddr = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      d     = 8'($urandom);
      clear = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        #1 model_reset();
        check_all();
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end
    clear = 1'b0; we = 1'b0; re = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
